// File: rtl/mult_div_unit_if.sv
// Operand, command and HI/LO result bundle between the issue logic and the mult/div unit.
// Requester drives the command side; the unit drives busy/done/hi/lo back.
interface mult_div_unit_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, a, b, mthi, mtlo, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, mthi, mtlo, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// 32-bit multiply/divide unit (shift-add / restoring), 32 iterations after acceptance, results in HI/LO.
// No queuing: start and mthi/mtlo are dropped while busy; start beats mthi/mtlo when idle.
module mult_div_unit (
  input  logic           clk,
  input  logic           rst_n,
  mult_div_unit_if.slave bus
);

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        is_div_q, is_div_d;
  logic        neg_res_q, neg_res_d;
  logic        neg_rem_q, neg_rem_d;
  logic        div0_q, div0_d;
  logic [31:0] opnd_q, opnd_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  logic        signed_op, a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum;
  logic [63:0] mul_step;
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] div_diff;
  logic [63:0] div_step;
  logic [63:0] step, prod;
  logic [31:0] quo, rem, res_hi, res_lo;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    signed_op = ~bus.op[0];
    a_neg     = signed_op & bus.a[31];
    b_neg     = signed_op & bus.b[31];
    a_mag     = a_neg ? (32'd0 - bus.a) : bus.a;
    b_mag     = b_neg ? (32'd0 - bus.b) : bus.b;

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    mul_step  = {mul_sum, acc_q[31:1]};

    // Divide: acc = {remainder, dividend/quotient}, shifted left each step.
    // When the trial subtract succeeds the true difference fits in 32 bits.
    div_shift = {acc_q[63:32], acc_q[31]};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    div_diff  = div_shift[31:0] - opnd_q;
    div_step  = div_ge ? {div_diff, acc_q[30:0], 1'b1}
                       : {div_shift[31:0], acc_q[30:0], 1'b0};

    step      = is_div_q ? div_step : mul_step;
    prod      = neg_res_q ? (64'd0 - step) : step;
    quo       = step[31:0];
    rem       = step[63:32];
    // Divide by zero naturally leaves |a| as remainder; only the quotient needs forcing.
    res_lo    = !is_div_q ? prod[31:0]
              : div0_q    ? 32'hFFFF_FFFF
              : (neg_res_q ? (32'd0 - quo) : quo);
    res_hi    = !is_div_q ? prod[63:32]
              : (neg_rem_q ? (32'd0 - rem) : rem);

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d   = S_RUN;
          cnt_d     = 5'd0;
          is_div_d  = bus.op[1];
          opnd_d    = bus.op[1] ? b_mag : a_mag;
          acc_d     = {32'd0, bus.op[1] ? a_mag : b_mag};
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          div0_d    = bus.op[1] & (bus.b == 32'd0);
        end else begin
          if (bus.mthi) hi_d = bus.wdata;
          if (bus.mtlo) lo_d = bus.wdata;
        end
      end
      S_RUN: begin
        acc_d = step;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = S_IDLE;
          hi_d    = res_hi;
          lo_d    = res_lo;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 5'd0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      opnd_q    <= 32'd0;
      acc_q     <= 64'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy = (state_q == S_RUN);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have no parameters; the operand width SHALL be fixed at 32 bits.
REQ-002 The block SHALL have one clock and a synchronous, active-low reset; ports SHALL be named clk and rst_n.
REQ-003 clk  input  1  rising-edge clock shared with reg_file and async_mem.
REQ-004 rst_n  input  1  synchronous reset, active low, sampled on the rising edge of clk.
REQ-005 start  input  1  request to begin an operation, qualified by busy=0.
REQ-006 op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-007 a  input  32  first operand (rs, from reg_file RD1).
REQ-008 b  input  32  second operand (rt, from reg_file RD2).
REQ-009 mthi  input  1  write wdata into HI.
REQ-010 mtlo  input  1  write wdata into LO.
REQ-011 wdata  input  32  data for MTHI/MTLO.
REQ-012 busy  output  1  operation in progress; registered.
REQ-013 done  output  1  one-cycle completion pulse; registered.
REQ-014 hi  output  32  HI register; registered; read by MFHI.
REQ-015 lo  output  32  LO register; registered; read by MFLO.

Function
REQ-016 Start acceptance: start=1 with busy=0 at rising edge N SHALL latch op, |a|, |b| and the result signs, and SHALL set busy=1 after edge N.
REQ-017 Sign handling for signed ops (MULT, DIV): operands SHALL be converted to magnitude at acceptance and the sign applied at completion; unsigned ops SHALL use operands unchanged.
REQ-018 Iteration: edges N+1 through N+32 SHALL each perform one iteration, with multiply as shift-add (1 bit per cycle) and divide as restoring (1 quotient bit per cycle).
REQ-019 Latency: at edge N+32, hi/lo SHALL take the final result, busy SHALL go to 0, and done SHALL go to 1 for exactly one cycle; busy SHALL be high for exactly 32 cycles.
REQ-020 Multiply result: {hi,lo} SHALL be the full 64-bit product, signed or unsigned per op.
REQ-021 Divide result: lo SHALL be the quotient truncated toward zero, and hi SHALL be the remainder with the dividend's sign.
REQ-022 Divide by zero (b=0): the result SHALL be lo=32'hFFFFFFFF and hi=a (unmodified dividend), for both DIV and DIVU, with the same 32-cycle latency.
REQ-023 Signed overflow: DIV 32'h80000000 / 32'hFFFFFFFF SHALL produce lo=32'h80000000 and hi=0.
REQ-024 start while busy=1 SHALL be ignored, with no queuing and no effect on the running operation.
REQ-025 mthi/mtlo while busy=0 SHALL update hi/lo at that edge, and both may be asserted together.
REQ-026 mthi/mtlo while busy=1 SHALL be ignored.
REQ-027 Simultaneous start and mthi/mtlo with busy=0: start SHALL win, and mthi/mtlo SHALL be ignored.
REQ-028 hi/lo SHALL hold their previous values throughout an operation and SHALL change only at the completion edge.
REQ-029 A new start SHALL be accepted in the cycle where done=1, since busy=0 in that cycle.
REQ-030 a and b SHALL be sampled only at acceptance; changes on a and b during busy SHALL have no effect.

Reset
REQ-031 rst_n=0 at a rising edge SHALL force busy=0, done=0, hi=0, lo=0, and clear the internal iteration counter.
REQ-032 Reset during an operation SHALL abort it, with no partial result written.
REQ-033 Reset SHALL take priority over start, mthi and mtlo.
REQ-034 The first start SHALL be accepted in the first cycle in which rst_n=1.

Verification
REQ-035 MULTU a=FFFFFFFF, b=FFFFFFFF -> after 32 busy cycles hi=FFFFFFFE, lo=00000001, with a single done pulse.
REQ-036 MULT a=FFFFFFFD (-3), b=00000007 -> hi=FFFFFFFF, lo=FFFFFFEB; DIV a=FFFFFFF9 (-7), b=00000002 -> lo=FFFFFFFD, hi=FFFFFFFF.
REQ-037 DIVU a=00000064, b=0 -> lo=FFFFFFFF, hi=00000064; DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=00000000.
REQ-038 Ignored requests: MULTU 3x5 started, then start (DIVU 9/3) and mthi wdata=DEADBEEF asserted at cycle 5 of busy -> final hi=00000000, lo=0000000F, and busy still falls after exactly 32 cycles.
REQ-039 mthi=mtlo=1, wdata=12345678, busy=0 -> hi=lo=12345678 next cycle; then start plus mtlo in the same cycle -> the operation starts and lo is unchanged until completion.
REQ-040 rst_n=0 at busy cycle 10 of DIVU FFFFFFFF/3 -> next cycle busy=0, done=0, hi=lo=0, and no later done pulse.
